// File: rtl/multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_core
// Purpose  : Multicycle RV32I/RV64I-subset integer core. Each instruction is
//            sequenced BOOT/FETCH -> DECODE -> EXEC -> WB, with BEQ/BNE
//            branches, R/I-type ALU ops, an illegal-instruction halt and a
//            per-instruction retire trace.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_core #(
    parameter int XLEN          = 32,
    parameter int NREGS         = 32,
    parameter int ENABLE_BRANCH = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] initial_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic            retire_valid,
    output logic [XLEN-1:0] retire_pc,
    output logic [31:0]     retire_instr,
    output logic [4:0]      retire_rd,
    output logic [XLEN-1:0] retire_wdata,
    output logic            halted
);

    localparam int         c_SH       = $clog2(XLEN);
    localparam int         c_RW       = $clog2(NREGS);
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_B     = 7'b1100011;
    // Upper immediate field of SRAI once the shift amount is shifted away
    localparam logic [11:0] c_SRAI_HI = 12'(12'h400 >> c_SH);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_ir;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_imm;
    logic              r_take;
    logic              r_req;
    logic              r_halted;
    logic              r_retire_valid;
    logic [XLEN-1:0]   r_retire_pc;
    logic [31:0]       r_retire_instr;
    logic [4:0]        r_retire_rd;
    logic [XLEN-1:0]   r_retire_wdata;
    logic [XLEN-1:0]   r_regs [NREGS];

    // Instruction fields
    logic [6:0]        w_opcode;
    logic [4:0]        w_rd;
    logic [2:0]        w_f3;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [6:0]        w_f7;
    logic [11:0]       w_imm_hi;
    logic [XLEN-1:0]   w_imm_i;
    logic [XLEN-1:0]   w_imm_b;
    logic              w_is_r;
    logic              w_is_i;
    logic              w_is_b;
    logic              w_rs1_ok;
    logic              w_rs2_ok;
    logic              w_rd_ok;
    logic              w_fmt_ok;
    logic              w_legal;
    logic              w_wr_en;
    logic [XLEN-1:0]   w_op_b;
    logic              w_alt;
    logic [c_SH-1:0]   w_shamt;
    logic [XLEN-1:0]   w_alu;
    logic              w_take;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_f3     = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_f7     = r_ir[31:25];
    assign w_imm_hi = r_ir[31:20] >> c_SH;
    assign w_imm_i  = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
    assign w_imm_b  = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

    assign w_is_r   = (w_opcode == c_OP_R);
    assign w_is_i   = (w_opcode == c_OP_I);
    assign w_is_b   = (w_opcode == c_OP_B) && (ENABLE_BRANCH != 0);
    // Register indices beyond the implemented file are illegal (RV32E style)
    assign w_rs1_ok = (int'(w_rs1) < NREGS);
    assign w_rs2_ok = (int'(w_rs2) < NREGS);
    assign w_rd_ok  = (int'(w_rd) < NREGS);
    assign w_wr_en  = (w_is_r || w_is_i) && (w_rd != 5'd0);

    // Legality of the instruction held in the IR
    always_comb begin
        w_fmt_ok = 1'b0;
        w_legal  = 1'b0;
        if (w_is_r) begin
            w_fmt_ok = (w_f7 == 7'b0000000) ||
                       ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
            w_legal  = w_fmt_ok && w_rs1_ok && w_rs2_ok && w_rd_ok;
        end else if (w_is_i) begin
            case (w_f3)
                3'b001:  w_fmt_ok = (w_imm_hi == 12'd0);
                3'b101:  w_fmt_ok = (w_imm_hi == 12'd0) || (w_imm_hi == c_SRAI_HI);
                default: w_fmt_ok = 1'b1;
            endcase
            w_legal = w_fmt_ok && w_rs1_ok && w_rd_ok;
        end else if (w_is_b) begin
            w_fmt_ok = (w_f3[2:1] == 2'b00);
            w_legal  = w_fmt_ok && w_rs1_ok && w_rs2_ok;
        end
    end

    // ALU: bit 30 selects SUB/SRA for R-type, and SRAI only for I-type shifts
    assign w_op_b  = w_is_r ? r_b : r_imm;
    assign w_alt   = (w_is_r || (w_f3 == 3'b101)) ? r_ir[30] : 1'b0;
    assign w_shamt = w_op_b[c_SH-1:0];
    assign w_take  = (r_a == r_b) ^ w_f3[0];

    // Result of the ALU operation selected by funct3
    always_comb begin
        w_alu = '0;
        case (w_f3)
            3'b000:  w_alu = w_alt ? (r_a - w_op_b) : (r_a + w_op_b);
            3'b001:  w_alu = r_a << w_shamt;
            3'b010:  w_alu = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_op_b))};
            3'b011:  w_alu = {{(XLEN-1){1'b0}}, (r_a < w_op_b)};
            3'b100:  w_alu = r_a ^ w_op_b;
            3'b101:  w_alu = w_alt ? $unsigned($signed(r_a) >>> w_shamt) : (r_a >> w_shamt);
            3'b110:  w_alu = r_a | w_op_b;
            default: w_alu = r_a & w_op_b;
        endcase
    end

    // Instruction sequencer, register file and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_BOOT;
            r_pc           <= '0;
            r_ir           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_imm          <= '0;
            r_take         <= 1'b0;
            r_req          <= 1'b0;
            r_halted       <= 1'b0;
            r_retire_valid <= 1'b0;
            r_retire_pc    <= '0;
            r_retire_instr <= '0;
            r_retire_rd    <= '0;
            r_retire_wdata <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_retire_valid <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    r_pc    <= initial_pc;
                    r_req   <= 1'b1;
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        r_ir    <= imem_rdata;
                        r_req   <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_a     <= r_regs[w_rs1[c_RW-1:0]];
                        r_b     <= r_regs[w_rs2[c_RW-1:0]];
                        r_imm   <= w_is_b ? w_imm_b : w_imm_i;
                        r_state <= S_EXEC;
                    end else begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end
                end
                S_EXEC: begin
                    // Retire fields are registered here so they are valid throughout WB
                    r_take         <= w_is_b && w_take;
                    r_retire_valid <= 1'b1;
                    r_retire_pc    <= r_pc;
                    r_retire_instr <= r_ir;
                    r_retire_rd    <= w_wr_en ? w_rd : 5'd0;
                    r_retire_wdata <= w_wr_en ? w_alu : '0;
                    r_state        <= S_WB;
                end
                S_WB: begin
                    if (r_retire_rd != 5'd0) begin
                        r_regs[r_retire_rd[c_RW-1:0]] <= r_retire_wdata;
                    end
                    r_pc    <= r_take ? (r_pc + r_imm) : (r_pc + XLEN'(4));
                    r_req   <= 1'b1;
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    assign imem_req     = r_req;
    assign imem_addr    = r_pc;
    assign retire_valid = r_retire_valid;
    assign retire_pc    = r_retire_pc;
    assign retire_instr = r_retire_instr;
    assign retire_rd    = r_retire_rd;
    assign retire_wdata = r_retire_wdata;
    assign halted       = r_halted;

endmodule
`default_nettype wire
